dmux_1by4_dispatcher: RTL and testbench

Round-robin stream dispatcher that drives the 1:4 demultiplexer path as a sequenced, flow-controlled block. It accepts one word at a time from a single upstream valid/ready source and routes each word to exactly one of four downstream channels. Channels are visited in rotating order, skipping any channel whose enable bit is clear. The block sits between a single producer and four consumers, and replaces a free-running select with handshake-safe sequencing.

---
 rtl/dmux_1by4_dispatcher.sv | 106 ++++++++++
 tb/tb_dmux_1by4_dispatcher.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_1by4_dispatcher.sv
// Round-robin 1:4 stream dispatcher: one holding register fed from a valid/ready
// source, each word routed to the next enabled channel in rotation.
module dmux_1by4_dispatcher #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    en_mask,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [1:0]    sel,
  output logic [15:0]   count
);

  // state | meaning
  // EMPTY | holding register free, outputs idle
  // HOLD  | word held for channel dest_q until out_ready[dest_q]
  typedef enum logic {EMPTY, HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    dest_q, dest_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [15:0]   count_q, count_d;

  logic       full;
  logic       out_fire;
  logic       in_fire;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  assign full     = (state_q == HOLD);
  assign out_fire = full & out_ready[dest_q];
  assign in_ready = (~full | out_fire) & (|en_mask) & ~rst;
  assign in_fire  = in_valid & in_ready;

  // First enabled channel at or after ptr_q, wrapping mod 4.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && en_mask[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + 16'd1;
    end
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_fire && !in_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (in_fire) begin
      data_d = in_data;
      dest_d = pick;
      ptr_d  = pick + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign out_valid = full ? (4'b0001 << dest_q) : 4'b0000;
  assign sel       = full ? dest_q : 2'd0;
  assign out_data  = data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dmux_1by4_dispatcher.sv
// Bench for dmux_1by4_dispatcher: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_dmux_1by4_dispatcher;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    en_mask;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [1:0]    sel;
  logic [15:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit            m_full;
  int            m_dest;
  int            m_ptr;
  logic [DW-1:0] m_data;
  int            m_count;

  dmux_1by4_dispatcher #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .en_mask(en_mask), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int first_en(int p, logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[(p + i) % 4]) return (p + i) % 4;
    end
    return p;
  endfunction

  function automatic bit m_in_ready();
    bit ofire;
    ofire = m_full && out_ready[m_dest];
    return (!m_full || ofire) && (en_mask != 4'b0) && !rst;
  endfunction

  function automatic logic [3:0] m_valid();
    return m_full ? 4'(1 << m_dest) : 4'b0000;
  endfunction

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic tick();
    bit ofire, ifire;
    int d;
    ofire = m_full && out_ready[m_dest];
    ifire = in_valid && m_in_ready();
    d = first_en(m_ptr, en_mask);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_dest = 0; m_ptr = 0; m_data = '0; m_count = 0;
    end else begin
      if (ofire) m_count = (m_count + 1) % 65536;
      if (ifire) begin
        m_full = 1; m_data = in_data; m_dest = d; m_ptr = (d + 1) % 4;
      end else if (ofire) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en_mask = 4'b1111; in_valid = 0; in_data = '0; out_ready = 4'b1111;
    tick(); tick();
    n_tests++;
    if (out_valid !== 4'b0 || sel !== 2'd0 || count !== 16'd0 || out_data !== '0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b sel=%0d count=%0d data=%h in_ready=%b exp 0000/0/0/00/0",
               out_valid, sel, count, out_data, in_ready);
    end
    rst = 0; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [3:0]    vexp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    en_mask = 4'b1111; out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = words[i]; #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== vexp[i] || out_data !== words[i]) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b data=%h exp %b/%h", i, out_valid, out_data, vexp[i], words[i]);
      end
    end
    in_valid = 0; tick();
    n_tests++;
    if (count !== 16'd5 || out_valid !== 4'b0) begin
      n_fail++; $display("FAIL stream_count: count=%0d valid=%b exp 5/0000", count, out_valid);
    end
  endtask

  task automatic test_skip();
    int dexp [4] = '{1, 3, 1, 3};
    en_mask = 4'b1010; out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'(8'hA0 + i);
      tick();
      n_tests++;
      if (sel !== 2'(dexp[i]) || out_valid !== 4'(1 << dexp[i]) || out_data !== 8'(8'hA0 + i)) begin
        n_fail++;
        $display("FAIL skip[%0d]: sel=%0d valid=%b data=%h exp %0d", i, sel, out_valid, out_data, dexp[i]);
      end
    end
    in_valid = 0; tick();
  endtask

  task automatic test_backpressure();
    int c;
    en_mask = 4'b1111; out_ready = 4'b1011;
    in_valid = 1; in_data = 8'hB1; tick();
    in_data = 8'hB2; tick();
    in_data = 8'hB3; tick();
    in_data = 8'hB4;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hB3 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid=%b sel=%0d data=%h in_ready=%b exp 0100/2/b3/0",
                 i, out_valid, sel, out_data, in_ready);
      end
      tick();
    end
    c = int'(count);
    out_ready = 4'b1111; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b exp 1", in_ready);
    end
    tick();
    n_tests++;
    if (int'(count) !== c + 1 || out_valid !== 4'b1000 || out_data !== 8'hB4) begin
      n_fail++;
      $display("FAIL release: count=%0d valid=%b data=%h exp %0d/1000/b4", count, out_valid, out_data, c + 1);
    end
    in_valid = 0; tick();
  endtask

  task automatic test_mask_hold();
    en_mask = 4'b0010; out_ready = 4'b0000;
    in_valid = 1; in_data = 8'hC1; tick();
    in_valid = 0; en_mask = 4'b1101;
    tick(); tick();
    n_tests++;
    if (out_valid !== 4'b0010 || out_data !== 8'hC1) begin
      n_fail++; $display("FAIL mask_hold: valid=%b data=%h exp 0010/c1", out_valid, out_data);
    end
    out_ready = 4'b0010; in_valid = 1; in_data = 8'hC2; tick();
    n_tests++;
    if (out_valid !== 4'b0100 || out_data !== 8'hC2) begin
      n_fail++; $display("FAIL mask_next: valid=%b data=%h exp 0100/c2", out_valid, out_data);
    end
    out_ready = 4'b1111; in_valid = 0; tick();
  endtask

  task automatic test_zero_mask_reset();
    int c;
    c = int'(count);
    en_mask = 4'b0000; in_valid = 1; in_data = 8'hD0; #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_ready: got %b exp 0", in_ready);
    end
    tick(); tick();
    n_tests++;
    if (out_valid !== 4'b0 || int'(count) !== c) begin
      n_fail++; $display("FAIL zero_mask_capture: valid=%b count=%0d exp 0000/%0d", out_valid, count, c);
    end
    en_mask = 4'b1111; out_ready = 4'b0000; in_data = 8'hD1; tick();
    n_tests++;
    if (out_valid !== 4'b1000) begin
      n_fail++; $display("FAIL zero_mask_ptr: valid=%b exp 1000", out_valid);
    end
    in_valid = 0; rst = 1; tick();
    n_tests++;
    if (out_valid !== 4'b0 || count !== 16'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset: valid=%b count=%0d in_ready=%b exp 0000/0/0", out_valid, count, in_ready);
    end
    rst = 0; out_ready = 4'b1111; in_valid = 1; in_data = 8'hD2; tick();
    n_tests++;
    if (out_valid !== 4'b0001 || out_data !== 8'hD2) begin
      n_fail++; $display("FAIL ptr_restart: valid=%b data=%h exp 0001/d2", out_valid, out_data);
    end
    in_valid = 0; tick();
  endtask

  task automatic test_random();
    int errs = 0;
    bit pend = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) en_mask = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      #1;
      n_tests++;
      if (in_ready !== m_in_ready() || out_valid !== m_valid() ||
          sel !== (m_full ? 2'(m_dest) : 2'd0) || out_data !== m_data || count !== 16'(m_count)) begin
        n_fail++;
        if (errs < 5)
          $display("FAIL random[%0d]: rdy=%b v=%b sel=%0d d=%h cnt=%0d exp rdy=%b v=%b d=%h cnt=%0d",
                   i, in_ready, out_valid, sel, out_data, count, m_in_ready(), m_valid(), m_data, m_count);
        errs++;
      end
      pend = in_valid && !m_in_ready();
      tick();
    end
    in_valid = 0; out_ready = 4'b1111; en_mask = 4'b1111; tick();
  endtask

  task automatic test_wrap();
    rst = 1; tick(); rst = 0;
    en_mask = 4'b1111; out_ready = 4'b1111; in_valid = 1;
    for (int i = 0; i < 65536; i++) begin
      in_data = 8'(i);
      tick();
    end
    n_tests++;
    if (count !== 16'hFFFF || m_count != 65535) begin
      n_fail++; $display("FAIL wrap_pre: got %h exp ffff", count);
    end
    tick();
    n_tests++;
    if (count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap: got %h exp 0000", count);
    end
    in_valid = 0; tick();
  endtask

  initial begin
    m_full = 0; m_dest = 0; m_ptr = 0; m_data = '0; m_count = 0;
    test_reset();
    test_stream();
    test_skip();
    test_backpressure();
    test_mask_hold();
    test_zero_mask_reset();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
